stream_range_gen: RTL and testbench



---
 rtl/stream_range_gen.sv | 114 +++++++++++
 tb/tb_stream_range_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_range_gen.sv
// stream_range_gen: arithmetic range stream producer.
// Takes one (start, step, count) command and emits count values
// start, start+step, ... on a valid/ready stream. The final beat carries last.
// An empty range (count=0) produces a single nil terminator beat.
//
// Build option: define STREAM_RANGE_GEN_PIPE_EN to accept the next command
// in the cycle the final beat transfers. Back-to-back streams then run at
// one beat per cycle. Without the macro there is one idle cycle between streams.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a command, cmd_ready high (unless in reset)
// S_EMIT | presenting r_val, r_rem beats still to go (incl. current)
// S_NIL  | presenting the empty-stream terminator (nil, last, data 0)

module stream_range_gen #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [N-1:0]  cmd_start,
  input  logic [N-1:0]  cmd_step,
  input  logic [CW-1:0] cmd_count,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  output logic          out_last,
  output logic          out_nil,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_NIL  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_val;
  logic [N-1:0]  r_stp;
  logic [CW-1:0] r_rem;

  logic w_rem_one;
  logic w_xfer;
  logic w_final;
  logic w_load;

  // Stream outputs and command handshake, decoded from the registered state.
  always_comb begin
    w_rem_one = (r_rem == CW'(1));
    out_valid = (r_state == S_EMIT) || (r_state == S_NIL);
    busy      = out_valid;
    out_nil   = (r_state == S_NIL);
    out_last  = (r_state == S_NIL) || ((r_state == S_EMIT) && w_rem_one);
    out_data  = (r_state == S_EMIT) ? r_val : '0;
    w_xfer    = out_valid && out_ready;
    w_final   = w_xfer && out_last;
    cmd_ready = 1'b0;
    case (r_state)
      // nrst gating keeps cmd_ready low while reset is held.
      S_IDLE:  cmd_ready = nrst;
`ifdef STREAM_RANGE_GEN_PIPE_EN
      S_EMIT:  cmd_ready = w_final;
      S_NIL:   cmd_ready = w_final;
`endif
      default: cmd_ready = 1'b0;
    endcase
    w_load = cmd_valid && cmd_ready;
  end

  // Next state: a load always wins, because it can only coincide with the final transfer.
  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = (cmd_count == '0) ? S_NIL : S_EMIT;
    end else if (w_final) begin
      w_state_nxt = S_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Range datapath: load on accept, advance on each non-final transfer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_val <= '0;
      r_stp <= '0;
      r_rem <= '0;
    end else if (w_load) begin
      r_val <= cmd_start;
      r_stp <= cmd_step;
      r_rem <= cmd_count;
    end else if (w_xfer && (r_state == S_EMIT)) begin
      if (w_rem_one) begin
        r_rem <= '0;
      end else begin
        r_val <= r_val + r_stp;
        r_rem <= r_rem - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_range_gen.sv
// Directed bench for stream_range_gen (N=8, CW=8). A negedge monitor
// records every transferred beat and checks that stalled beats stay stable.
module tb_stream_range_gen;

  localparam int N  = 8;
  localparam int CW = 8;
`ifdef STREAM_RANGE_GEN_PIPE_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  logic          clk = 1'b0;
  logic          nrst;
  logic [N-1:0]  cmd_start;
  logic [N-1:0]  cmd_step;
  logic [CW-1:0] cmd_count;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_nil;
  logic          out_ready;
  logic          busy;

  stream_range_gen #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cmd_start (cmd_start),
    .cmd_step  (cmd_step),
    .cmd_count (cmd_count),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_nil   (out_nil),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       nil;
    int         cyc;
  } beat_t;

  typedef struct {
    logic [7:0]      start;
    logic [7:0]      step;
    logic [7:0]      count;
    int              nexp;
    logic [3:0][7:0] exp_d;
  } vec_t;

  beat_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  logic       p_valid = 1'b0;
  logic       p_ready = 1'b0;
  logic [7:0] p_data  = '0;
  logic       p_last  = 1'b0;
  logic       p_nil   = 1'b0;

  // Record transfers and check that a stalled beat is held unchanged.
  always @(negedge clk) begin
    if (nrst) begin
      if (p_valid && !p_ready) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(p_data));
        chk("hold_last", 32'(out_last), 32'(p_last));
        chk("hold_nil", 32'(out_nil), 32'(p_nil));
      end
      if (out_valid && out_ready) q.push_back('{out_data, out_last, out_nil, cyc});
    end
    p_valid <= out_valid && nrst;
    p_ready <= out_ready;
    p_data  <= out_data;
    p_last  <= out_last;
    p_nil   <= out_nil;
  end

  // Caller is in the cycle after an edge with the DUT idle.
  task automatic send_cmd(input logic [7:0] s, input logic [7:0] st, input logic [7:0] c);
    cmd_start = s;
    cmd_step  = st;
    cmd_count = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string nm);
    int k = 0;
    while (q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk({nm, "_beats_seen"}, 32'(q.size() >= n), 32'd1);
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    q.delete();
    out_ready = 1'b1;
    send_cmd(v.start, v.step, v.count);
    chk($sformatf("v%0d_first_valid", vi), 32'(out_valid), 32'd1);
    chk($sformatf("v%0d_busy", vi), 32'(busy), 32'd1);
    if (v.count >= 8'd2) chk($sformatf("v%0d_rdy_busy", vi), 32'(cmd_ready), 32'd0);
    wait_beats(v.nexp, 20, $sformatf("v%0d", vi));
    if (q.size() == v.nexp) begin
      for (int i = 0; i < v.nexp; i++) begin
        chk($sformatf("v%0d_data%0d", vi, i), 32'(q[i].data), 32'(v.exp_d[i]));
        chk($sformatf("v%0d_last%0d", vi, i), 32'(q[i].last), 32'(i == v.nexp - 1));
        chk($sformatf("v%0d_nil%0d", vi, i), 32'(q[i].nil), 32'(v.count == 8'd0));
        chk($sformatf("v%0d_cyc%0d", vi, i), 32'(q[i].cyc - q[0].cyc), 32'(i));
      end
    end else begin
      chk($sformatf("v%0d_count", vi), 32'(q.size()), 32'(v.nexp));
    end
    chk($sformatf("v%0d_rdy_after", vi), 32'(cmd_ready), 32'd1);
    chk($sformatf("v%0d_idle_after", vi), 32'(out_valid), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nlast;
    int acc;
    logic rdy;
    logic [5:0] pat;

    vecs[0] = '{8'd5,   8'd3,   8'd4, 4, {8'd14, 8'd11, 8'd8,   8'd5}};
    vecs[1] = '{8'd9,   8'd1,   8'd0, 1, {8'd0,  8'd0,  8'd0,   8'd0}};
    vecs[2] = '{8'd254, 8'd1,   8'd3, 3, {8'd0,  8'd0,  8'd255, 8'd254}};
    vecs[3] = '{8'd1,   8'd255, 8'd3, 3, {8'd0,  8'd255, 8'd0,  8'd1}};
    vecs[4] = '{8'd100, 8'd156, 8'd2, 2, {8'd0,  8'd0,  8'd0,   8'd100}};

    nrst = 1'b0;
    cmd_start = '0; cmd_step = '0; cmd_count = '0; cmd_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_nil", 32'(out_nil), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    #1;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int v = 0; v < 5; v++) run_vec(v, vecs[v]);

    // Backpressure: ready pattern 1,0,0,1,0,1 from the first valid cycle.
    q.delete();
    out_ready = 1'b1;
    send_cmd(8'd0, 8'd1, 8'd3);
    pat = 6'b101001;
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i];
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    chk("bp_count", 32'(q.size()), 32'd3);
    if (q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bp_data%0d", i), 32'(q[i].data), 32'(i));
        chk($sformatf("bp_last%0d", i), 32'(q[i].last), 32'(i == 2));
      end
    end
    chk("bp_idle", 32'(out_valid), 32'd0);

    // Longest range for CW=8.
    q.delete();
    send_cmd(8'd0, 8'd1, 8'd255);
    wait_beats(255, 300, "max");
    repeat (3) @(posedge clk);
    #1;
    chk("max_count", 32'(q.size()), 32'd255);
    if (q.size() == 255) begin
      nlast = 0;
      foreach (q[i]) if (q[i].last) nlast++;
      chk("max_first", 32'(q[0].data), 32'd0);
      chk("max_final", 32'(q[254].data), 32'd254);
      chk("max_final_last", 32'(q[254].last), 32'd1);
      chk("max_one_last", 32'(nlast), 32'd1);
    end

    // Reset during a count=10 stream, after two beats have transferred.
    q.delete();
    send_cmd(8'd0, 8'd1, 8'd10);
    wait_beats(2, 10, "mid");
    chk("mid_active", 32'(out_valid), 32'd1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    #1;
    chk("mid_rel_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rel_valid", 32'(out_valid), 32'd0);
    q.delete();
    send_cmd(8'd7, 8'd0, 8'd2);
    wait_beats(2, 10, "post");
    chk("post_count", 32'(q.size()), 32'd2);
    if (q.size() == 2) begin
      chk("post_d0", 32'(q[0].data), 32'd7);
      chk("post_d1", 32'(q[1].data), 32'd7);
      chk("post_l0", 32'(q[0].last), 32'd0);
      chk("post_l1", 32'(q[1].last), 32'd1);
    end

    // Back-to-back commands with cmd_valid held high.
    q.delete();
    out_ready = 1'b1;
    cmd_start = 8'd10; cmd_step = 8'd1; cmd_count = 8'd2;
    cmd_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 20 && acc < 2; k++) begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc++;
        if (acc == 1) begin
          cmd_start = 8'd20; cmd_step = 8'd2; cmd_count = 8'd2;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd2);
    wait_beats(4, 10, "b2b");
    chk("b2b_count", 32'(q.size()), 32'd4);
    if (q.size() == 4) begin
      chk("b2b_d0", 32'(q[0].data), 32'd10);
      chk("b2b_d1", 32'(q[1].data), 32'd11);
      chk("b2b_d2", 32'(q[2].data), 32'd20);
      chk("b2b_d3", 32'(q[3].data), 32'd22);
      chk("b2b_l1", 32'(q[1].last), 32'd1);
      chk("b2b_l3", 32'(q[3].last), 32'd1);
      chk("b2b_l0", 32'(q[0].last), 32'd0);
      chk("b2b_gap01", 32'(q[1].cyc - q[0].cyc), 32'd1);
      chk("b2b_gap12", 32'(q[2].cyc - q[1].cyc), 32'(GAP));
      chk("b2b_gap23", 32'(q[3].cyc - q[2].cyc), 32'd1);
    end
    chk("b2b_idle", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
